pipe_skid_stage: RTL and testbench

//  Parametrised pipeline stage register: the next generation of the fixed-field

---
 rtl/pipe_skid_stage.sv | 109 ++++++++++
 tb/tb_pipe_skid_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Ready depends only on registered state; it also has a synchronous flush and a saturating stall counter.
module pipe_skid_stage #(
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               acc;
    logic               pop;

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;
    assign occupancy = state_q;

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    // In SKID the stage refuses input, so main is refilled only from the skid entry.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (CLEAR_DATA) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = FULL;
                        main_d  = in_data;
                    end
                end
                FULL: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        state_d = FULL;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios plus random valid/ready traffic
// against a queue-based reference model, on a default instance and a CNT_W=3/CLEAR_DATA=0 one.
module tb_pipe_skid_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        stat_clr;

    logic        in_ready_a, out_valid_a;
    logic [31:0] out_data_a;
    logic [15:0] stall_cnt_a;
    logic [1:0]  occupancy_a;

    logic        in_ready_b, out_valid_b;
    logic [31:0] out_data_b;
    logic [2:0]  stall_cnt_b;
    logic [1:0]  occupancy_b;

    int checks_total;
    int checks_passed;

    logic [31:0] held[$];
    logic [31:0] last_a;
    logic [31:0] last_b;
    int          cnt_a;
    int          cnt_b;
    logic [31:0] delivered[$];

    pipe_skid_stage #(.DATA_W(32), .CLEAR_DATA(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .flush(flush), .stat_clr(stat_clr),
        .stall_cnt(stall_cnt_a), .occupancy(occupancy_a)
    );

    pipe_skid_stage #(.DATA_W(32), .CLEAR_DATA(1'b0), .CNT_W(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .flush(flush), .stat_clr(stat_clr),
        .stall_cnt(stall_cnt_b), .occupancy(occupancy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        held.delete();
        last_a = '0;
        last_b = '0;
        cnt_a  = 0;
        cnt_b  = 0;
    endtask

    // The model is a bounded FIFO of up to two payloads; head of the queue is what downstream sees.
    task automatic model_edge(input logic v, input logic [31:0] d, input logic r,
                              input logic f, input logic c);
        bit has   = held.size() > 0;
        bit stall = has && !r;
        bit pop   = has && r;
        bit acc   = v && (held.size() < 2);
        if (c) begin
            cnt_a = 0;
            cnt_b = 0;
        end else if (stall) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 7) cnt_b++;
        end
        if (f) begin
            held.delete();
            last_a = '0;
        end else begin
            if (pop) void'(held.pop_front());
            if (acc) held.push_back(d);
            if (held.size() > 0) begin
                last_a = held[0];
                last_b = held[0];
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] occ_exp;
        occ_exp = 32'(held.size());
        checkOutput("occ_a", 32'(occupancy_a), occ_exp);
        checkOutput("occ_b", 32'(occupancy_b), occ_exp);
        checkOutput("in_ready_a", 32'(in_ready_a), 32'(held.size() < 2));
        checkOutput("in_ready_b", 32'(in_ready_b), 32'(held.size() < 2));
        checkOutput("out_valid_a", 32'(out_valid_a), 32'(held.size() > 0));
        checkOutput("out_valid_b", 32'(out_valid_b), 32'(held.size() > 0));
        checkOutput("out_data_a", out_data_a, last_a);
        checkOutput("out_data_b", out_data_b, last_b);
        checkOutput("stall_cnt_a", 32'(stall_cnt_a), 32'(cnt_a));
        checkOutput("stall_cnt_b", 32'(stall_cnt_b), 32'(cnt_b));
    endtask

    // One clock: drive inputs, log a handshake about to complete, clock, update the model, check.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r,
                                 input logic f, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        stat_clr  = c;
        #1;
        if (out_valid_a && out_ready) delivered.push_back(out_data_a);
        @(posedge clk);
        model_edge(v, d, r, f, c);
        #1;
        check_all();
    endtask

    task automatic check_delivered(input string tag, input logic [31:0] exp[$]);
        checkOutput({tag, "_count"}, 32'(delivered.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < delivered.size(); i++)
            checkOutput(tag, delivered[i], exp[i]);
    endtask

    initial begin
        logic [31:0] exp_q[$];
        checks_total  = 0;
        checks_passed = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stat_clr  = 1'b0;
        reset_n   = 1'b0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Streaming at full rate.
        delivered.delete();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
            if (i == 1) begin
                checkOutput("stream_first_valid", 32'(out_valid_a), 32'd1);
                checkOutput("stream_first_data", out_data_a, 32'h1);
            end
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        exp_q = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8};
        check_delivered("stream_order", exp_q);

        // Backpressure fills the skid entry and holds the third payload upstream.
        delivered.delete();
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_occupancy", 32'(occupancy_a), 32'd2);
        checkOutput("bp_in_ready", 32'(in_ready_a), 32'd0);
        checkOutput("bp_hold_data", out_data_a, 32'hA);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        exp_q = {32'hA, 32'hB, 32'hC};
        check_delivered("bp_order", exp_q);

        // Flush from SKID with a payload offered in the same cycle.
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_occ", 32'(occupancy_a), 32'd0);
        checkOutput("flush_valid", 32'(out_valid_a), 32'd0);
        checkOutput("flush_ready", 32'(in_ready_a), 32'd1);
        checkOutput("flush_clear_data", out_data_a, 32'h0);
        checkOutput("flush_keep_data", out_data_b, 32'h11);
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        checkOutput("post_flush_valid", 32'(out_valid_a), 32'd1);
        checkOutput("post_flush_data", out_data_a, 32'h55);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall counter saturation on the 3-bit instance, then clear during a stall.
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("cnt_saturate", 32'(stall_cnt_b), 32'd7);
        checkOutput("cnt_wide", 32'(stall_cnt_a), 32'd10);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("cnt_clear_b", 32'(stall_cnt_b), 32'd0);
        checkOutput("cnt_clear_a", 32'(stall_cnt_a), 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and counter clear.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(),
                          1'($urandom_range(0, 9) < 7),
                          1'($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 127) == 0));
        end

        // Async reset asserted mid-cycle while both entries are held.
        applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hD2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hD3, 1'b0, 1'b0, 1'b0);
        checkOutput("pre_reset_occ", 32'(occupancy_a), 32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_ready", 32'(in_ready_a), 32'd1);
        checkOutput("rst_data", out_data_a, 32'h0);
        checkOutput("rst_data_b", out_data_b, 32'h0);
        checkOutput("rst_cnt", 32'(stall_cnt_a), 32'd0);
        checkOutput("rst_occ", 32'(occupancy_a), 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b1, 32'hE1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
